// File: rtl/countdown_timer.sv
// Loadable countdown timer with one-shot, periodic-reload and wrap modes.
// Counts down by DECREMENT on each tick while RUNNING and pulses expired on underflow.
module countdown_timer #(
    parameter  int MAX_VALUE = 255,
    parameter  int DECREMENT = 1,
    localparam int W         = $clog2(MAX_VALUE + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic [1:0]   mode,
    input  logic         start,
    input  logic         stop,
    input  logic         tick,
    output logic [W-1:0] count,
    output logic         running,
    output logic         done,
    output logic         expired
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [W-1:0] MAX_W = W'(MAX_VALUE);
    localparam logic [W-1:0] DEC_W = W'(DECREMENT);

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic [W-1:0] r_reload;
    logic [W-1:0] w_reload_next;
    logic         r_expired;
    logic         w_expired_next;
    logic [W-1:0] w_load_clamped;

    // When MAX_VALUE fills the whole W-bit range no load value can exceed it.
    generate
        if (MAX_VALUE == (2 ** W) - 1) begin : g_no_clamp
            assign w_load_clamped = load_value;
        end else begin : g_clamp
            assign w_load_clamped = (load_value > MAX_W) ? MAX_W : load_value;
        end
    endgenerate

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_reload_next  = r_reload;
        w_expired_next = 1'b0;

        if (load) begin
            w_count_next  = w_load_clamped;
            w_reload_next = w_load_clamped;
            if (r_state == ST_DONE) w_state_next = ST_IDLE;
        end else if (stop) begin
            w_state_next = ST_IDLE;
        end else if (start && (r_state != ST_RUNNING)) begin
            w_state_next = ST_RUNNING;
        end else if (tick && (r_state == ST_RUNNING)) begin
            // Compare before subtracting so the count can never wrap below zero.
            if (r_count >= DEC_W) begin
                w_count_next = r_count - DEC_W;
            end else begin
                w_expired_next = 1'b1;
                case (mode)
                    2'b01:   w_count_next = r_reload;
                    2'b10:   w_count_next = MAX_W;
                    default: begin
                        w_count_next = '0;
                        w_state_next = ST_DONE;
                    end
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_reload  <= '0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_reload  <= w_reload_next;
            r_expired <= w_expired_next;
        end
    end

    assign count   = r_count;
    assign running = (r_state == ST_RUNNING);
    assign done    = (r_state == ST_DONE);
    assign expired = r_expired;

endmodule
